// File: rtl/ethernet_mmio_initiator_if.sv
// Bundles the host MMIO request/response channel and the Ethernet controller's
// synchronous register port into one interface.
interface ethernet_mmio_initiator_if #(
  parameter int data_width_p = 32
);
  localparam int addr_width_lp = 14;
  localparam int size_width_lp = $clog2($clog2(data_width_p / 8) + 1);

  // host request channel
  logic                     req_v_i;
  logic                     req_ready_and_o;
  logic                     req_w_i;
  logic [addr_width_lp-1:0] req_addr_i;
  logic [size_width_lp-1:0] req_size_i;
  logic [data_width_p-1:0]  req_data_i;

  // host response channel
  logic                     resp_v_o;
  logic                     resp_ready_and_i;
  logic                     resp_w_o;
  logic                     resp_err_o;
  logic [data_width_p-1:0]  resp_data_o;

  // controller register port
  logic [addr_width_lp-1:0] addr_o;
  logic                     write_en_o;
  logic                     read_en_o;
  logic [size_width_lp-1:0] op_size_o;
  logic [data_width_p-1:0]  write_data_o;
  logic [data_width_p-1:0]  read_data_i;

  modport slave (
    input  req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i,
    input  resp_ready_and_i, read_data_i,
    output req_ready_and_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o,
    output addr_o, write_en_o, read_en_o, op_size_o, write_data_o
  );

  modport master (
    output req_v_i, req_w_i, req_addr_i, req_size_i, req_data_i,
    output resp_ready_and_i, read_data_i,
    input  req_ready_and_o, resp_v_o, resp_w_o, resp_err_o, resp_data_o,
    input  addr_o, write_en_o, read_en_o, op_size_o, write_data_o
  );
endinterface

// File: rtl/ethernet_mmio_initiator.sv
// Host-side MMIO initiator: two-stage strobe/sample pipeline into the Ethernet
// controller register port, with credit-guarded in-order response FIFO.
module ethernet_mmio_initiator #(
  parameter int data_width_p = 32,
  parameter int resp_els_p   = 4
) (
  input logic                      clk_i,
  input logic                      reset_n_i,
  ethernet_mmio_initiator_if.slave bus
);
  localparam int addr_width_lp = 14;
  localparam int max_size_lp   = $clog2(data_width_p / 8);
  localparam int size_width_lp = $clog2(max_size_lp + 1);
  localparam int ptr_width_lp  = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_width_lp  = $clog2(resp_els_p + 1);

  typedef struct packed {
    logic                    w;
    logic                    err;
    logic [data_width_p-1:0] data;
  } resp_t;

  logic                     run_r;
  logic                     ready;
  logic                     accept;
  logic                     req_err;
  logic [addr_width_lp-1:0] align_mask;

  logic                     s1_v, s1_w, s1_err;
  logic                     s2_v, s2_w, s2_err, s2_rd;
  logic                     write_en_r, read_en_r;
  logic [addr_width_lp-1:0] addr_r;
  logic [size_width_lp-1:0] size_r;
  logic [data_width_p-1:0]  wdata_r;

  resp_t                    mem [resp_els_p];
  logic [ptr_width_lp-1:0]  head, tail;
  logic [cnt_width_lp-1:0]  count;
  logic                     enq, deq, resp_v;
  resp_t                    enq_entry, head_entry;

  // Alignment: low req_size_i address bits must be zero.
  assign align_mask = ~({addr_width_lp{1'b1}} << bus.req_size_i);
  assign req_err    = (bus.req_size_i > size_width_lp'(max_size_lp)) ||
                      ((bus.req_addr_i & align_mask) != '0);

  // Reserve a FIFO slot for every request still in S1/S2 so the pipeline never stalls.
  assign ready  = run_r && ((int'(count) + int'(s1_v) + int'(s2_v)) < resp_els_p);
  assign accept = bus.req_v_i && ready;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      run_r      <= 1'b0;
      s1_v       <= 1'b0;
      s1_w       <= 1'b0;
      s1_err     <= 1'b0;
      s2_v       <= 1'b0;
      s2_w       <= 1'b0;
      s2_err     <= 1'b0;
      s2_rd      <= 1'b0;
      write_en_r <= 1'b0;
      read_en_r  <= 1'b0;
      addr_r     <= '0;
      size_r     <= '0;
      wdata_r    <= '0;
    end else begin
      run_r      <= 1'b1;
      s1_v       <= accept;
      s1_w       <= bus.req_w_i;
      s1_err     <= req_err;
      write_en_r <= accept &&  bus.req_w_i && !req_err;
      read_en_r  <= accept && !bus.req_w_i && !req_err;
      if (accept) begin
        addr_r  <= bus.req_addr_i;
        size_r  <= bus.req_size_i;
        wdata_r <= bus.req_data_i;
      end
      s2_v   <= s1_v;
      s2_w   <= s1_w;
      s2_err <= s1_err;
      s2_rd  <= read_en_r;
    end
  end

  // read_data_i is only meaningful in the cycle after a real read strobe.
  always_comb begin
    enq_entry      = '0;
    enq_entry.w    = s2_w;
    enq_entry.err  = s2_err;
    enq_entry.data = s2_rd ? bus.read_data_i : '0;
  end

  assign enq    = s2_v;
  assign resp_v = (count != '0);
  assign deq    = resp_v && bus.resp_ready_and_i;

  always_ff @(posedge clk_i) begin
    if (enq) mem[tail] <= enq_entry;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= (tail == ptr_width_lp'(resp_els_p - 1)) ? '0 : tail + ptr_width_lp'(1);
      if (deq) head <= (head == ptr_width_lp'(resp_els_p - 1)) ? '0 : head + ptr_width_lp'(1);
      case ({enq, deq})
        2'b10:   count <= count + cnt_width_lp'(1);
        2'b01:   count <= count - cnt_width_lp'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[head];

  assign bus.req_ready_and_o = ready;
  assign bus.resp_v_o        = resp_v;
  assign bus.resp_w_o        = resp_v && head_entry.w;
  assign bus.resp_err_o      = resp_v && head_entry.err;
  assign bus.resp_data_o     = resp_v ? head_entry.data : '0;

  assign bus.write_en_o      = write_en_r;
  assign bus.read_en_o       = read_en_r;
  assign bus.addr_o          = addr_r;
  assign bus.op_size_o       = size_r;
  assign bus.write_data_o    = wdata_r;
endmodule
